// File: rtl/l1_data_array_ctrl_if.sv
// Requester and SRAM-facing signal bundle for the L1 data-array controller.
// The slave modport is the controller; master is the requester/SRAM side.
interface l1_data_array_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned NUM_WMASKS = 32
);
  logic                  fill_valid;
  logic                  fill_ready;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  st_valid;
  logic                  st_ready;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic [NUM_WMASKS-1:0] st_be;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_rvalid;
  logic [DATA_WIDTH-1:0] ld_rdata;
  logic                  init_done;
  logic                  csb0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;

  modport slave (
    input  fill_valid, fill_addr, fill_data,
    input  st_valid, st_addr, st_data, st_be,
    input  ld_valid, ld_addr, dout1,
    output fill_ready, st_ready, ld_ready, ld_rvalid, ld_rdata, init_done,
    output csb0, wmask0, addr0, din0, csb1, addr1
  );

  modport master (
    output fill_valid, fill_addr, fill_data,
    output st_valid, st_addr, st_data, st_be,
    output ld_valid, ld_addr, dout1,
    input  fill_ready, st_ready, ld_ready, ld_rvalid, ld_rdata, init_done,
    input  csb0, wmask0, addr0, din0, csb1, addr1
  );
endinterface

// File: rtl/l1_data_array_ctrl.sv
// L1 data-array controller: clears the SRAM after reset, then arbitrates fills
// and stores onto the write port and pipelines loads through the read port.
module l1_data_array_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned NUM_WMASKS   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  l1_data_array_ctrl_if.slave bus
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  init_done_q, init_done_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  ld_rvalid_q, ld_rvalid_d;
  logic [DATA_WIDTH-1:0] ld_rdata_q, ld_rdata_d;

  logic                  run;
  logic                  fill_gnt;
  logic                  st_gnt;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  ld_ok;
  logic                  ld_fire;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    init_done_d = init_done_q;
    ld_rdata_d  = ld_rdata_q;

    run      = (state_q == ST_RUN);
    // A fill wins unless the waiting store has already lost STARVE_LIMIT times.
    fill_gnt = run && bus.fill_valid &&
               !(bus.st_valid && (starve_q == STARVE_W'(STARVE_LIMIT)));
    st_gnt   = run && bus.st_valid && !fill_gnt;
    wr_en    = fill_gnt || st_gnt;
    wr_addr  = fill_gnt ? bus.fill_addr : bus.st_addr;
    ld_ok    = run && !(wr_en && (wr_addr == bus.ld_addr));
    ld_fire  = ld_ok && bus.ld_valid;

    rd_pend_d   = ld_fire;
    ld_rvalid_d = rd_pend_q;
    if (rd_pend_q) ld_rdata_d = bus.dout1;

    bus.csb0   = 1'b1;
    bus.wmask0 = '0;
    bus.addr0  = '0;
    bus.din0   = '0;

    if (state_q == ST_INIT) begin
      bus.csb0   = 1'b0;
      bus.wmask0 = {NUM_WMASKS{1'b1}};
      bus.addr0  = cnt_q;
      cnt_d      = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == '1) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end else if (wr_en) begin
      bus.csb0   = 1'b0;
      bus.wmask0 = fill_gnt ? {NUM_WMASKS{1'b1}} : bus.st_be;
      bus.addr0  = wr_addr;
      bus.din0   = fill_gnt ? bus.fill_data : bus.st_data;
    end

    if (run) begin
      if (!bus.st_valid || st_gnt) starve_d = '0;
      else if (fill_gnt)           starve_d = starve_q + STARVE_W'(1);
    end

    bus.fill_ready = fill_gnt;
    bus.st_ready   = st_gnt;
    bus.ld_ready   = ld_ok;
    bus.csb1       = !ld_fire;
    bus.addr1      = bus.ld_addr;

    // Keep both SRAM ports and all handshakes quiet while reset is held.
    if (!rst_n) begin
      bus.csb0       = 1'b1;
      bus.csb1       = 1'b1;
      bus.fill_ready = 1'b0;
      bus.st_ready   = 1'b0;
      bus.ld_ready   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      starve_q    <= '0;
      init_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      ld_rvalid_q <= 1'b0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      init_done_q <= init_done_d;
      rd_pend_q   <= rd_pend_d;
      ld_rvalid_q <= ld_rvalid_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  assign bus.init_done = init_done_q;
  assign bus.ld_rvalid = ld_rvalid_q;
  assign bus.ld_rdata  = ld_rdata_q;

endmodule

// File: doc/l1_data_array_ctrl.md
L1_DATA_ARRAY_CTRL -- requirements
Module: l1_data_array_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, SRAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 256, SRAM word width.
REQ-003 SHALL have parameter NUM_WMASKS, default 32, byte-lane count (DATA_WIDTH/8).
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, max consecutive fill grants while a store waits.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports:
- clk  in  1  sole clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have the following requester ports:
- fill_valid  in  1  line-fill write request.
- fill_ready  out  1  fill accepted this cycle.
- fill_addr  in  ADDR_WIDTH  fill address.
- fill_data  in  DATA_WIDTH  fill line.
- st_valid  in  1  store request.
- st_ready  out  1  store accepted this cycle.
- st_addr  in  ADDR_WIDTH  store address.
- st_data  in  DATA_WIDTH  store data.
- st_be  in  NUM_WMASKS  store byte enables.
- ld_valid  in  1  load request.
- ld_ready  out  1  load accepted this cycle.
- ld_addr  in  ADDR_WIDTH  load address.
- ld_rvalid  out  1  load data valid.
- ld_rdata  out  DATA_WIDTH  registered load data.
- init_done  out  1  array clear complete.
REQ-007 SHALL have the following SRAM ports:
- csb0  out  1  write-port select, active low.
- wmask0  out  NUM_WMASKS  write byte mask.
- addr0  out  ADDR_WIDTH  write address.
- din0  out  DATA_WIDTH  write data.
- csb1  out  1  read-port select, active low.
- addr1  out  ADDR_WIDTH  read address.
- dout1  in  DATA_WIDTH  read data; valid from mid-cycle N+1 for a read issued in cycle N.

Function
REQ-008 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-009 SHALL, in INIT, write one word per cycle at counter addresses 0..RAM_DEPTH-1: csb0=0, wmask0=all ones, din0=0, addr0=counter.
REQ-010 SHALL transition INIT->RUN in the cycle after address RAM_DEPTH-1 is issued, and raise init_done there; init_done stays 1 until reset.
REQ-011 SHALL hold fill_ready, st_ready, ld_ready and csb1 deasserted (csb1=1) throughout INIT.
REQ-012 SHALL, in RUN, drive the write port combinationally from the granted requester; handshake completes when valid && ready in the same cycle.
REQ-013 SHALL grant a fill over a waiting store, except when starve_cnt == STARVE_LIMIT, in which case the store is granted.
REQ-014 SHALL increment starve_cnt on each fill grant while st_valid=1, and clear it on any store grant or any cycle with st_valid=0.
REQ-015 SHALL drive wmask0=all ones for fills, wmask0=st_be for stores; a store with st_be=0 SHALL still be accepted and issue csb0=0.
REQ-016 SHALL drive csb0=1 when no write is granted.
REQ-017 SHALL issue load reads on port 1 (csb1=0, addr1=ld_addr) when ld_ready && ld_valid.
REQ-018 SHALL deassert ld_ready when a write is granted in the same cycle to addr0 == ld_addr, forbidding a same-cycle, same-address read and write.
REQ-019 SHALL register dout1 on the posedge ending cycle N+1 and assert ld_rvalid with ld_rdata in cycle N+2 for a load accepted in cycle N; loads are fully pipelined, one per cycle, with no response backpressure.
REQ-020 SHALL keep ld_rdata stable when ld_rvalid=0.

Reset
REQ-021 SHALL, on rst_n=0, asynchronously:
- force state=INIT, counter=0, starve_cnt=0;
- force init_done=0, ld_rvalid=0, ld_rdata=0;
- force csb0=1, csb1=1, all ready outputs=0.
REQ-022 SHALL discard an in-flight load response on reset, and restart the clear from address 0 if reset occurs mid-INIT.

Verification
REQ-023 SHALL verify init: release reset -> 256 consecutive writes to addresses 0..255 with din0=0; init_done=1 at cycle 257; a later load to addr 0x3F returns 0.
REQ-024 SHALL verify byte-masked store: store addr 0x10, data all 0xAA, st_be=0x0000000F; then load 0x10 -> ld_rdata low 4 bytes 0xAA, others 0x00, ld_rvalid 2 cycles after acceptance.
REQ-025 SHALL verify the starvation guard: fill_valid and st_valid held high -> 4 fill grants, then 1 store grant, repeating.
REQ-026 SHALL verify the hazard stall: fill to 0x20 with same-cycle load to 0x20 -> ld_ready=0 that cycle; load accepted next cycle and returns the fill data.
REQ-027 SHALL verify back-to-back loads: loads to 0x01, 0x02, 0x03 on consecutive cycles -> three consecutive ld_rvalid cycles, data in order.
REQ-028 SHALL verify reset mid-INIT: assert rst_n=0 at counter 100 -> clear restarts at 0; init_done=0 until the full 256-cycle sweep completes.
